// File: rtl/csr_enc_dbg_pkg.sv
// Shared types and sizing constants for the csr_enc debug/monitor blocks.
package csr_enc_dbg_pkg;

  localparam int AXIS_PORTS = 4;
  localparam int NUM_INST   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } dd_state_e;

endpackage

// File: rtl/csr_enc_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module csr_enc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/csr_enc_hls_deadlock_detector.sv
// Confirms a deadlock once the idx0 monitor reports block for CONFIRM_CYCLES
// consecutive cycles, then holds a sticky flag plus debug snapshots until cleared.
module csr_enc_hls_deadlock_detector
  import csr_enc_dbg_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  monitor_block,
  input  logic [AXIS_PORTS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0]   inst_idle_sigs,
  input  logic                  clear,
  output logic                  deadlock_detected,
  output logic                  deadlock_pulse,
  output logic [AXIS_PORTS-1:0] axis_snapshot,
  output logic [NUM_INST-1:0]   idle_snapshot,
  output logic [CNT_W-1:0]      deadlock_count,
  output logic [CNT_W-1:0]      false_alarm_count
);

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);

  dd_state_e        state, next_state;
  logic [CNT_W-1:0] run, next_run;
  logic             confirm, abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      run   <= '0;
    end else begin
      state <= next_state;
      run   <= next_run;
    end
  end

  // run counts the consecutive blocked samples already seen in SUSPECT
  always_comb begin
    next_state = state;
    next_run   = run;
    if (clear) begin
      next_state = IDLE;
      next_run   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (monitor_block) begin
            if (CONFIRM_CYCLES == 1) begin
              next_state = DEADLOCK;
              next_run   = '0;
            end else begin
              next_state = SUSPECT;
              next_run   = RUN_ONE;
            end
          end
        end
        SUSPECT: begin
          if (!monitor_block) begin
            next_state = IDLE;
            next_run   = '0;
          end else if (run == RUN_LAST) begin
            next_state = DEADLOCK;
            next_run   = '0;
          end else begin
            next_run = run + RUN_ONE;
          end
        end
        DEADLOCK: begin
          next_state = DEADLOCK;
        end
        default: begin
          next_state = IDLE;
          next_run   = '0;
        end
      endcase
    end
  end

  // clear already forces next_state to IDLE, so it masks both events here
  always_comb begin
    confirm = 1'b0;
    abort   = 1'b0;
    if (state != DEADLOCK && next_state == DEADLOCK) begin
      confirm = 1'b1;
    end
    if (state == SUSPECT && next_state == IDLE && !clear) begin
      abort = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deadlock_detected <= 1'b0;
      deadlock_pulse    <= 1'b0;
      axis_snapshot     <= '0;
      idle_snapshot     <= '0;
    end else if (clear) begin
      deadlock_detected <= 1'b0;
      deadlock_pulse    <= 1'b0;
      axis_snapshot     <= '0;
      idle_snapshot     <= '0;
    end else begin
      deadlock_pulse <= confirm;
      if (confirm) begin
        deadlock_detected <= 1'b1;
        axis_snapshot     <= axis_block_sigs;
        idle_snapshot     <= inst_idle_sigs;
      end
    end
  end

  csr_enc_sat_counter #(.W(CNT_W)) u_deadlock_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (confirm),
    .value (deadlock_count)
  );

  csr_enc_sat_counter #(.W(CNT_W)) u_false_alarm_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (abort),
    .value (false_alarm_count)
  );

endmodule
